stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- 1-to-2 stream demultiplexer with valid/ready handshake; the inverse of the 2:1 word multiplexer used in the datapath.
- Routes a packet of WIDTH-bit beats to output port 0 or 1.
- Output port is chosen by in_sel on the first beat and locked until the beat carrying in_last.
- Each output has a one-entry register slot, so both outputs are registered and the two directions drain independently.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 16, width of optional per-port beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  1  destination port; sampled only on the first beat of a packet.
- in_last  input  1  final beat of the packet.
- out0_valid  output  1  port 0 slot full.
- out0_ready  input  1  port 0 consumer ready.
- out0_data  output  WIDTH  port 0 payload.
- out0_last  output  1  port 0 last flag.
- out1_valid, out1_ready, out1_data, out1_last: same as port 0, for port 1.
- cnt0  output  CNT_W  port 0 beats delivered (only with STREAM_DEMUX_CNT_EN).
- cnt1  output  CNT_W  port 1 beats delivered (only with STREAM_DEMUX_CNT_EN).

Behaviour:
- Reset is asynchronous and active-low on rst_n, clocked on clk.
- Reset values:
  - FSM = IDLE.
  - Both slots empty: outX_valid=0, outX_data=0, outX_last=0.
  - cnt0=cnt1=0.
  - in_ready is combinational and reads 1 in IDLE with empty slots.
- FSM states: IDLE, ROUTE0, ROUTE1.
  - IDLE: the target is in_sel.
  - On an accepted beat with in_last=0, go to ROUTE{in_sel}.
  - On an accepted beat with in_last=1 (single-beat packet), stay in IDLE.
  - ROUTE0/ROUTE1: target is fixed and in_sel is ignored.
  - An accepted beat with in_last=1 returns the FSM to IDLE.
- Slot rule per port X: slot_free_X = !outX_valid || outX_ready.
- in_ready = slot_free of the current target; the other port never backpressures the input.
- Accepted beat: written into the target slot on the next edge. Latency is 1 cycle from acceptance to outX_valid=1.
- Output drain: when outX_valid && outX_ready, the slot clears unless it is refilled in the same cycle. A simultaneous drain and fill gives full throughput, one beat per cycle per port.
- Slot contents are stable while outX_valid && !outX_ready. outX_data and outX_last must not change.
- The non-target slot keeps draining during a packet to the other port.
- in_data, in_sel and in_last are ignored when in_valid=0.
- Reset mid-packet: the FSM returns to IDLE and the slots are flushed. Any partial packet is discarded, with no recovery.
- in_valid may drop mid-packet: the FSM holds its ROUTE state.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined: cnt0 and cnt1 ports exist. Each increments by 1 on every outX_valid && outX_ready handshake. Each wraps modulo 2^CNT_W, from all-ones to 0. Both reset to 0.
- Undefined: the cnt ports and the counter logic are absent. Port list ends at out1_last.

Decomposition:
- Package stream_demux_pkg holds:
  - the state encoding constants: ST_IDLE=2'd0, ST_ROUTE0=2'd1, ST_ROUTE1=2'd2;
  - PORT0=1'b0 and PORT1=1'b1.
- Sub-module demux_slot, instantiated twice. It is the one-entry register slot: wr_en, wr_data, wr_last, valid, ready, data, last, slot_free, plus the optional counter.
- The FSM and routing logic live in the top level.

Test Plan:
- Reset: hold rst_n=0 -> out0_valid=out1_valid=0, in_ready=1, cnt0=cnt1=0. Release reset -> no spurious valid.
- Single-beat to port 1: in_sel=1, in_last=1, in_data=8'hA5, out1_ready=1 -> next cycle out1_valid=1, out1_data=A5, out1_last=1. out0_valid stays 0 and the FSM stays in IDLE.
- Locked 3-beat packet: beats 11, 22, 33 with in_sel=0 on beat 1 and in_sel=1 on beats 2-3 -> all three appear on port 0 in order, with last only on 33. Port 1 stays idle. Both ports ready gives one beat per cycle.
- Backpressure: out0_ready=0 during a packet to port 0 -> after one beat, in_ready=0 and out0_data is held stable. Raising out0_ready resumes transfer with no loss or duplication.
- Independent drain: port 1 holds 8'h77 with out1_ready=0 while a packet goes to port 0 -> the port 0 packet completes, and port 1 still holds 77 until out1_ready=1.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4 -> slots empty and FSM in IDLE. The next packet with in_sel=1 routes to port 1. With STREAM_DEMUX_CNT_EN defined, 2^CNT_W+1 handshakes on port 0 -> cnt0=1.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux block: FSM state encoding,
// output port identifiers and the routing-target helper.
package stream_demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUTE0 = 2'd1,
      ST_ROUTE1 = 2'd2
   } state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Port a beat goes to: in_sel only while no packet is open, otherwise the locked port.
   function automatic logic route_target(input state_e st, input logic sel);
      logic tgt;
      tgt = PORT0;
      case (st)
         ST_IDLE:   tgt = sel;
         ST_ROUTE0: tgt = PORT0;
         ST_ROUTE1: tgt = PORT1;
         default:   tgt = PORT0;
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle of stream_demux: one input stream and two output streams.
// Optional beat counters appear only when STREAM_DEMUX_CNT_EN is defined.
interface stream_demux_if #(
   parameter int WIDTH = 8
`ifdef STREAM_DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_last;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_last;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_last;
`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
`endif

   // Demux side.
   modport slave (
      input  in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out0_last,
             out1_valid, out1_data, out1_last
`ifdef STREAM_DEMUX_CNT_EN
      , output cnt0, cnt1
`endif
   );

   // Producer/consumer side.
   modport master (
      output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out0_last,
             out1_valid, out1_data, out1_last
`ifdef STREAM_DEMUX_CNT_EN
      , input cnt0, cnt1
`endif
   );

endinterface

// File: rtl/stream_demux_slot.sv
// demux_slot: one-entry output register slot with valid/ready drain and an
// optional delivered-beat counter (STREAM_DEMUX_CNT_EN).
module demux_slot #(
   parameter int WIDTH = 8
`ifdef STREAM_DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_last,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last,
   output logic             slot_free
`ifdef STREAM_DEMUX_CNT_EN
   , output logic [CNT_W-1:0] cnt
`endif
);

   logic             valid_r;
   logic [WIDTH-1:0] data_r;
   logic             last_r;

   // Slot register: a write wins over a drain so drain+fill keeps full throughput.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {WIDTH{1'b0}};
         last_r  <= 1'b0;
      end else if (wr_en) begin
         valid_r <= 1'b1;
         data_r  <= wr_data;
         last_r  <= wr_last;
      end else if (ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid     = valid_r;
   assign data      = data_r;
   assign last      = last_r;
   assign slot_free = !valid_r || ready;

`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Delivered-beat counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (valid_r && ready) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
`endif

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 packet demultiplexer, port locked from first beat to last beat.
// Per-port beat counters are added when STREAM_DEMUX_CNT_EN is defined.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8
`ifdef STREAM_DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_demux_if.slave  bus
);

   state_e state_r;
   state_e state_next_s;
   logic   target_s;
   logic   free0_s;
   logic   free1_s;
   logic   in_ready_s;
   logic   accept_s;
   logic   wr0_s;
   logic   wr1_s;

   assign target_s    = route_target(state_r, bus.in_sel);
   assign in_ready_s  = (target_s == PORT1) ? free1_s : free0_s;
   assign accept_s    = bus.in_valid && in_ready_s;
   assign wr0_s       = accept_s && (target_s == PORT0);
   assign wr1_s       = accept_s && (target_s == PORT1);
   assign bus.in_ready = in_ready_s;

   // Packet-lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: open a packet on a non-last beat, close it on the last beat.
   always_comb begin
      state_next_s = state_r;
      if (accept_s) begin
         if (bus.in_last) begin
            state_next_s = ST_IDLE;
         end else if (target_s == PORT1) begin
            state_next_s = ST_ROUTE1;
         end else begin
            state_next_s = ST_ROUTE0;
         end
      end else if ((state_r == ST_IDLE) || (state_r == ST_ROUTE0) || (state_r == ST_ROUTE1)) begin
         state_next_s = state_r;
      end else begin
         state_next_s = ST_IDLE;
      end
   end

   demux_slot #(
      .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr0_s),
      .wr_data   (bus.in_data),
      .wr_last   (bus.in_last),
      .ready     (bus.out0_ready),
      .valid     (bus.out0_valid),
      .data      (bus.out0_data),
      .last      (bus.out0_last),
      .slot_free (free0_s)
`ifdef STREAM_DEMUX_CNT_EN
      , .cnt     (bus.cnt0)
`endif
   );

   demux_slot #(
      .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr1_s),
      .wr_data   (bus.in_data),
      .wr_last   (bus.in_last),
      .ready     (bus.out1_ready),
      .valid     (bus.out1_valid),
      .data      (bus.out1_data),
      .last      (bus.out1_last),
      .slot_free (free1_s)
`ifdef STREAM_DEMUX_CNT_EN
      , .cnt     (bus.cnt1)
`endif
   );

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-port expected-beat queues filled by the
// stimulus side, drained and compared by an independent output monitor.
module tb_stream_demux;

   localparam int WIDTH = 8;
`ifdef STREAM_DEMUX_CNT_EN
   localparam int CNT_W = 4;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   stream_demux_if #(
      .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) bus ();

   stream_demux #(
      .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   bit    pkt_open  = 1'b0;
   bit    lock_port = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] exp_cnt0 = '0;
   logic [CNT_W-1:0] exp_cnt1 = '0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: each slot must hold exactly the oldest undelivered beat.
   initial begin
      forever begin
         @(negedge clk);
         #2;
`ifdef STREAM_DEMUX_CNT_EN
         check("cnt0", 32'(bus.cnt0), 32'(exp_cnt0));
         check("cnt1", 32'(bus.cnt1), 32'(exp_cnt1));
`endif
         check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
         if (q0.size() != 0) begin
            check("out0_data", 32'(bus.out0_data), 32'(q0[0].data));
            check("out0_last", 32'(bus.out0_last), 32'(q0[0].last));
            if (bus.out0_ready && bus.out0_valid) begin
               void'(q0.pop_front());
`ifdef STREAM_DEMUX_CNT_EN
               exp_cnt0 = exp_cnt0 + 1'b1;
`endif
            end
         end
         check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
         if (q1.size() != 0) begin
            check("out1_data", 32'(bus.out1_data), 32'(q1[0].data));
            check("out1_last", 32'(bus.out1_last), 32'(q1[0].last));
            if (bus.out1_ready && bus.out1_valid) begin
               void'(q1.pop_front());
`ifdef STREAM_DEMUX_CNT_EN
               exp_cnt1 = exp_cnt1 + 1'b1;
`endif
            end
         end
      end
   end

   // One cycle of stimulus; acceptance and destination come from the packet model.
   task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit sel,
                        input bit last, input bit r0, input bit r1);
      bit tgt;
      bit exp_rdy;
      bit acc;
      @(negedge clk);
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.in_sel     = sel;
      bus.in_last    = last;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      #1;
      tgt     = pkt_open ? lock_port : sel;
      exp_rdy = tgt ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
         if (tgt) q1.push_back('{data: d, last: last});
         else     q0.push_back('{data: d, last: last});
         if (last) begin
            pkt_open = 1'b0;
         end else begin
            pkt_open  = 1'b1;
            lock_port = tgt;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      q0.delete();
      q1.delete();
      pkt_open = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
      exp_cnt0 = '0;
      exp_cnt1 = '0;
`endif
      repeat (cycles) @(negedge clk);
      #1;
      check("in_ready_rst", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_sel     = 1'b0;
      bus.in_last    = 1'b0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      do_reset(3);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Single-beat packet to port 1.
      drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Three beats locked to port 0 despite in_sel changing.
      drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Backpressure on port 0.
      drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Port 1 stalls holding 77 while a packet with a valid gap goes to port 0.
      drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h83, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Reset after two beats of a four-beat packet, then a packet to port 1.
      drive(1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h92, 1'b0, 1'b0, 1'b1, 1'b1);
      do_reset(2);
      drive(1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1);
         end else begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
         end
      end

      repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
